// File: rtl/avalon_vector_master_if.sv
// Avalon-MM command/response bundle between the vector master and one dpRam slave port.
// Latency: pure wiring, no registers.
// Backpressure: the slave stalls the master by raising waitrequest.
interface avalon_vector_master_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic                  waitrequest;

    modport master (
        output read, write, address, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_vector_master.sv
// Avalon-MM initiator: fills a RAM window with LFSR words, or reads it back, counting mismatches and folding a checksum.
// Latency: first command the cycle after start; reads pipelined with a fixed READ_LATENCY return path.
// Backpressure: commands are held stable while waitrequest=1; WAITREQUEST_TIMEOUT_EN adds a 255-cycle stall abort.
module avalon_vector_master #(
    parameter int          ADDR_WIDTH   = 5,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SEED         = 32'h00000001
) (
    input  logic                   avalon_clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  base,
    input  logic [ADDR_WIDTH:0]    count,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH:0]    error_count,
    output logic [31:0]            checksum,
    output logic                   timeout,
    avalon_vector_master_if.master av
);

    localparam logic [31:0]         SEED_EFF = (SEED == 32'd0) ? 32'h00000001 : SEED;
    localparam logic [31:0]         POLY     = 32'h80200003;
    localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? POLY : 32'd0);
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [ADDR_WIDTH:0]     err_q, err_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic [31:0]             cs_q, cs_d;
    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;

    logic start_ok;
    logic cmd_vld;
    logic accept;
    logic last_cmd;
    logic capture;
    logic abort;

    assign start_ok = (state_q == S_IDLE) && start;
    assign cmd_vld  = (state_q == S_WRITE) || (state_q == S_READ);
    assign accept   = cmd_vld && !av.waitrequest;
    assign last_cmd = (idx_q + IDX_ONE) == cnt_q;
    // The top bit of the valid pipe marks the cycle readdata belongs to an accepted read.
    assign capture  = vld_sr_q[READ_LATENCY-1];

`ifdef WAITREQUEST_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_q, timeout_d;
    logic       stall;

    assign stall = cmd_vld && av.waitrequest;
    // The 255th consecutive stalled cycle drops the command.
    assign abort = stall && (to_cnt_q == 8'd254);

    always_comb begin
        to_cnt_d  = 8'd0;
        timeout_d = timeout_q;
        if (stall)    to_cnt_d  = to_cnt_q + 8'd1;
        if (start_ok) timeout_d = 1'b0;
        if (abort)    timeout_d = 1'b1;
    end

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) state_d = S_DONE;
                    else if (mode)   state_d = S_READ;
                    else             state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort)                    state_d = S_DONE;
                else if (accept && last_cmd)  state_d = S_DONE;
            end
            S_READ: begin
                if (abort)                    state_d = S_DONE;
                else if (accept && last_cmd)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (vld_sr_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        av.read      = 1'b0;
        av.write     = 1'b0;
        av.address   = '0;
        av.writedata = 32'd0;
        case (state_q)
            S_WRITE: begin
                busy         = 1'b1;
                av.write     = 1'b1;
                av.address   = base_q + idx_q[ADDR_WIDTH-1:0];
                av.writedata = lfsr_q;
            end
            S_READ: begin
                busy       = 1'b1;
                av.read    = 1'b1;
                av.address = base_q + idx_q[ADDR_WIDTH-1:0];
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        err_d       = err_q;
        cs_d        = cs_q;
        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = accept && (state_q == S_READ);

        if (start_ok) begin
            base_d = base;
            cnt_d  = count;
            idx_d  = '0;
            lfsr_d = SEED_EFF;
            err_d  = '0;
            cs_d   = 32'd0;
        end

        if (accept) idx_d = idx_q + IDX_ONE;
        if (accept && (state_q == S_WRITE)) lfsr_d = lfsr_next(lfsr_q);

        // In verify mode the LFSR tracks returned data, not issued addresses.
        if (capture) begin
            lfsr_d = lfsr_next(lfsr_q);
            if ((av.readdata != lfsr_q) && (err_q != ERR_MAX)) err_d = err_q + IDX_ONE;
            cs_d = {cs_q[30:0], cs_q[31]} ^ av.readdata;
        end

        if (abort) vld_sr_d = '0;
    end

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            base_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            lfsr_q   <= SEED_EFF;
            err_q    <= '0;
            cs_q     <= 32'd0;
            vld_sr_q <= '0;
        end else begin
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
            vld_sr_q <= vld_sr_d;
        end
    end

    assign error_count = err_q;
    assign checksum    = cs_q;

endmodule
